// File: rtl/morse_receiver.sv
// Morse receiver for letters A..H: synchronizes the keyed line, classifies marks
// as dots/dashes by length, and decodes the symbol sequence once the line stays quiet.
module morse_receiver #(
  parameter int UNIT_CYCLES = 25_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       morse_in,
  output logic [2:0] letter,
  output logic       letter_valid,
  output logic       letter_error,
  output logic       busy,
  output logic [1:0] fsm_state
);

  localparam int CW = $clog2(UNIT_CYCLES);
  localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    GAP   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          sync1;
  logic          syn;
  logic [CW-1:0] cyc;
  logic [2:0]    units;
  logic [3:0]    sym;
  logic [2:0]    cnt;

  logic          unit_end;
  logic          mark_max;
  logic          gap_done;
  logic          clr;
  logic          do_append;
  logic          is_dash;
  logic          valid_set;
  logic          error_set;
  logic          dec_ok;
  logic [2:0]    dec_letter;

  // Elapsed time in the current state is units*UNIT_CYCLES + cyc.
  assign unit_end = (cyc == CYC_LAST);
  assign mark_max = (units == 3'd4) && unit_end;
  assign gap_done = (units == 3'd2) && unit_end;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      syn   <= 1'b0;
    end else begin
      sync1 <= morse_in;
      syn   <= sync1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (syn) state_next = MARK;
      MARK: begin
        if (!syn)          state_next = (cnt == 3'd4) ? FLUSH : GAP;
        else if (mark_max) state_next = FLUSH;
      end
      GAP: begin
        if (syn)           state_next = MARK;
        else if (gap_done) state_next = IDLE;
      end
      FLUSH: if (!syn && gap_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    do_append  = (state == MARK) && !syn && (cnt != 3'd4);
    is_dash    = (units >= 3'd2);
    dec_ok     = 1'b1;
    dec_letter = 3'd0;
    // Pattern occupies sym[cnt-1:0] with the first symbol in the highest used bit.
    case ({cnt, sym})
      {3'd2, 4'b0001}: dec_letter = 3'd0;
      {3'd4, 4'b1000}: dec_letter = 3'd1;
      {3'd4, 4'b1010}: dec_letter = 3'd2;
      {3'd3, 4'b0100}: dec_letter = 3'd3;
      {3'd1, 4'b0000}: dec_letter = 3'd4;
      {3'd4, 4'b0010}: dec_letter = 3'd5;
      {3'd3, 4'b0110}: dec_letter = 3'd6;
      {3'd4, 4'b0000}: dec_letter = 3'd7;
      default:         dec_ok     = 1'b0;
    endcase
    valid_set = (state == GAP) && !syn && gap_done && dec_ok;
    error_set = ((state == GAP) && !syn && gap_done && !dec_ok) ||
                ((state == MARK) && ((!syn && cnt == 3'd4) || (syn && mark_max)));
    busy      = (state != IDLE);
    fsm_state = state;
  end

  // A mark during FLUSH restarts the quiet-time measurement.
  assign clr = (state_next != state) || ((state == FLUSH) && syn);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc   <= '0;
      units <= 3'd0;
    end else if (clr) begin
      cyc   <= '0;
      units <= 3'd0;
    end else if (unit_end) begin
      cyc   <= '0;
      if (units != 3'd7) units <= units + 3'd1;
    end else begin
      cyc <= cyc + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sym <= 4'd0;
      cnt <= 3'd0;
    end else if (state == IDLE) begin
      sym <= 4'd0;
      cnt <= 3'd0;
    end else if (do_append) begin
      sym <= {sym[2:0], is_dash};
      cnt <= cnt + 3'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      letter       <= 3'd0;
      letter_valid <= 1'b0;
      letter_error <= 1'b0;
    end else begin
      letter_valid <= valid_set;
      letter_error <= error_set;
      if (valid_set) letter <= dec_letter;
    end
  end

endmodule

// File: doc/morse_receiver.md
MORSE_RECEIVER -- requirements
Module: morse_receiver

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 25_000_000, meaning clock cycles per Morse time unit (0.5 s at 50 MHz); legal range 2..2^26.
REQ-002 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port morse_in, input, 1, asynchronous keyed line, 1 = mark (LED on), 0 = space.
REQ-005 SHALL have port letter, output, 3, last decoded letter code: A=000, B=001, C=010, D=011, E=100, F=101, G=110, H=111.
REQ-006 SHALL have port letter_valid, output, 1, one-cycle pulse when letter is updated.
REQ-007 SHALL have port letter_error, output, 1, one-cycle pulse when a symbol sequence is rejected.
REQ-008 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-009 SHALL pass morse_in through a 2-flop synchronizer; the second flop output (syn) is the only form of morse_in used downstream.
REQ-010 SHALL time intervals with a cycle counter (0..UNIT_CYCLES-1) plus a 3-bit unit counter saturating at 7, both cleared on every FSM state change.
REQ-011 SHALL hold a 4-bit symbol shift register (dot=0, dash=1, newest symbol in bit 0) and a 3-bit symbol count (0..4).
REQ-012 SHALL implement FSM states IDLE, MARK, GAP, FLUSH; reset state IDLE.
REQ-013 IDLE: symbol register and count cleared; syn=1 -> MARK.
REQ-014 MARK: length m counts consecutive syn=1 cycles from entry; on syn=0 with m < 2*UNIT_CYCLES, append dot; with 2*UNIT_CYCLES <= m < 5*UNIT_CYCLES, append dash; then -> GAP.
REQ-015 MARK: when m reaches 5*UNIT_CYCLES with syn still 1, SHALL pulse letter_error on the next cycle and -> FLUSH.
REQ-016 MARK: on syn=0 with symbol count already 4 (fifth symbol), SHALL pulse letter_error and -> FLUSH instead of appending.
REQ-017 GAP: syn=1 before 3*UNIT_CYCLES consecutive syn=0 cycles -> MARK (inter-symbol gap).
REQ-018 GAP: on the 3*UNIT_CYCLES-th consecutive syn=0 cycle, SHALL decode (count, pattern) and -> IDLE; letter_valid/letter_error pulse on the following cycle, coincident with IDLE.
REQ-019 Decode table (count:pattern, first symbol MSB): 2:01=A, 4:1000=B, 4:1010=C, 3:100=D, 1:0=E, 4:0010=F, 3:110=G, 4:0000=H; every other combination SHALL pulse letter_error with letter unchanged.
REQ-020 On valid decode, letter SHALL update in the same cycle letter_valid pulses and hold until the next valid decode.
REQ-021 FLUSH: SHALL discard input; consecutive-syn=0 timing restarts whenever syn=1; after 3*UNIT_CYCLES consecutive syn=0 cycles -> IDLE with no output pulse.
REQ-022 letter_valid and letter_error SHALL never be high in the same cycle; each SHALL be high for exactly one cycle per event.
REQ-023 SHALL accept the timing produced by the team's Morse transmitter (dot ~1 unit, dash ~3 units, inter-symbol gap ~1 unit, plus a few cycles of FSM overhead) and decode its output correctly.

Reset
REQ-024 Reset SHALL asynchronously force state IDLE, synchronizer flops, counters, symbol register and count to 0, letter=000, letter_valid=0, letter_error=0, busy=0.
REQ-025 Reset asserted mid-letter SHALL discard partial symbols with no output pulse; decoding resumes on the first mark after release.

Verification (UNIT_CYCLES=4)
REQ-026 A: mark 4, space 4, mark 12, space >=12 cycles -> letter=000, single letter_valid pulse 12 space cycles (+2 sync) after the dash ends, busy low afterward.
REQ-027 C: marks 12,4,12,4 separated by 4-cycle spaces, then idle -> letter=010 with one letter_valid pulse; then E (single 4-cycle mark) -> letter=100.
REQ-028 M ("--"): two 12-cycle marks, 4-cycle space, then idle -> letter_error pulse, letter keeps prior value, no letter_valid.
REQ-029 Long mark: morse_in high 30 cycles -> letter_error pulse once 20 synced high cycles elapse; state FLUSH; IDLE only after 12 consecutive low cycles; no further pulses.
REQ-030 Five dots (4-cycle marks, 4-cycle spaces) -> letter_error at end of fifth mark, then FLUSH; no letter_valid.
REQ-031 Reset pulse during second symbol of B -> all outputs zero immediately; following clean H sequence -> letter=111 valid.
